// File: rtl/vga_pkg.sv
// Default 640x480@60 Hz raster timing and shared helpers for the VGA timing block.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 1;

  function automatic logic in_span(coord_t v, int unsigned lo, int unsigned hi);
    return (32'(v) >= lo) && (32'(v) <= hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter; resets to MAX so the first enable lands on 0.
module mod_counter
  import vga_pkg::*;
#(
  parameter int unsigned MAX = 799
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t count,
  output coord_t count_nxt,
  output logic   wrap
);

  always_comb begin
    wrap      = en && (count == coord_t'(MAX));
    count_nxt = count;
    if (en) begin
      count_nxt = wrap ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= coord_t'(MAX);
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator advanced by rising edges of a clk-synchronous pixel strobe.
module vga_timing #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixel_clk,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = V_ACTIVE + V_FP + V_SYNC - 1;

  logic            pclk_d;
  logic            adv;
  logic            h_wrap;
  logic            v_wrap;
  vga_pkg::coord_t h_nxt;
  vga_pkg::coord_t v_nxt;

  assign adv = pixel_clk & ~pclk_d;

  mod_counter #(
    .MAX(HTotal - 1)
  ) u_h_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv),
    .count    (pixel_x),
    .count_nxt(h_nxt),
    .wrap     (h_wrap)
  );

  mod_counter #(
    .MAX(VTotal - 1)
  ) u_v_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv & h_wrap),
    .count    (pixel_y),
    .count_nxt(v_nxt),
    .wrap     (v_wrap)
  );

  // Decoding the next-state counts keeps every registered output aligned with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pclk_d      <= 1'b0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
    end else begin
      pclk_d      <= pixel_clk;
      pixel_tick  <= adv;
      frame_start <= v_wrap;
      hsync       <= ~vga_pkg::in_span(h_nxt, HsStart, HsEnd);
      vsync       <= ~vga_pkg::in_span(v_nxt, VsStart, VsEnd);
      video_on    <= (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default 640x480 raster plus a shrunken raster for whole-frame behaviour.
module tb_vga_timing;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pixel_clk;
  logic       pixel_tick, hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic       s_tick, s_hsync, s_vsync, s_video, s_fs;
  logic [9:0] s_x, s_y;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  vga_timing u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_clk  (pixel_clk),
    .pixel_tick (pixel_tick),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_start(frame_start)
  );

  // 14x8 raster: hsync low at x=10..11, vsync low at y=5..6, visible 8x4.
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_clk  (pixel_clk),
    .pixel_tick (s_tick),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .video_on   (s_video),
    .pixel_x    (s_x),
    .pixel_y    (s_y),
    .frame_start(s_fs)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic p);
    pixel_clk = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_first, hs_last, hs_cnt, vo_first, vo_cnt, ybad, xbad, ticks, fss, moved;
    int s_fs_cnt, s_vs_cnt, s_vs_min, s_vs_max, s_vid_cnt, wrap_ok, d_vs_cnt, d_fs_cnt;
    int prev_x, prev_y;

    rst_n = 1'b0;
    pixel_clk = 1'b0;
    repeat (3) cyc(1'b0);
    check("rst_x", pixel_x, 799);
    check("rst_y", pixel_y, 524);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_video", video_on, 0);
    check("rst_fs", frame_start, 0);
    check("rst_tick", pixel_tick, 0);
    check("rst_small_x", s_x, 13);
    check("rst_small_y", s_y, 7);

    rst_n = 1'b1;
    repeat (4) cyc(1'b0);
    check("pre_tick", pixel_tick, 0);
    cyc(1'b1);
    check("first_tick", pixel_tick, 1);
    check("first_x", pixel_x, 0);
    check("first_y", pixel_y, 0);
    check("first_fs", frame_start, 1);
    check("first_video", video_on, 1);
    check("first_hsync", hsync, 1);
    check("first_vsync", vsync, 1);
    check("first_small_fs", s_fs, 1);
    cyc(1'b0);
    check("tick_drop", pixel_tick, 0);
    check("fs_drop", frame_start, 0);
    check("hold_x", pixel_x, 0);
    repeat (2) cyc(1'b0);

    // One full line at the 1-in-4 strobe rate.
    hs_first = -1; hs_last = -1; hs_cnt = 0; vo_first = -1; vo_cnt = 0;
    ybad = 0; xbad = 0; ticks = 0;
    for (int i = 1; i < 800; i++) begin
      cyc(1'b1);
      ticks += int'(pixel_tick);
      if (pixel_x !== 10'(i)) xbad++;
      if (pixel_y !== 10'd0) ybad++;
      if (hsync === 1'b0) begin
        if (hs_cnt == 0) hs_first = int'(pixel_x);
        hs_last = int'(pixel_x);
        hs_cnt++;
      end
      if (video_on === 1'b0) begin
        if (vo_cnt == 0) vo_first = int'(pixel_x);
        vo_cnt++;
      end
      repeat (3) cyc(1'b0);
    end
    check("line_x_track", xbad, 0);
    check("line_y_steady", ybad, 0);
    check("line_ticks", ticks, 799);
    check("hsync_first", hs_first, 656);
    check("hsync_last", hs_last, 751);
    check("hsync_width", hs_cnt, 96);
    check("video_off_first", vo_first, 640);
    check("video_off_count", vo_cnt, 160);
    cyc(1'b1);
    check("wrap_x", pixel_x, 0);
    check("wrap_y", pixel_y, 1);
    check("wrap_video", video_on, 1);
    check("wrap_fs", frame_start, 0);
    repeat (3) cyc(1'b0);

    // Strobe held high: a single advance.
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1);
      ticks += int'(pixel_tick);
    end
    cyc(1'b0);
    ticks += int'(pixel_tick);
    check("held_ticks", ticks, 1);
    check("held_x", pixel_x, 1);
    check("held_y", pixel_y, 1);

    // Strobe stuck low: everything holds.
    ticks = 0; fss = 0; moved = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0);
      ticks += int'(pixel_tick);
      fss += int'(frame_start);
      if (pixel_x !== 10'd1 || pixel_y !== 10'd1 || video_on !== 1'b1 || hsync !== 1'b1)
        moved++;
    end
    check("idle_ticks", ticks, 0);
    check("idle_fs", fss, 0);
    check("idle_moved", moved, 0);

    // Fastest legal strobe, then reset mid-line coinciding with a rising strobe.
    for (int i = 0; i < 299; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    check("fast_x", pixel_x, 300);
    check("fast_y", pixel_y, 1);
    rst_n = 1'b0;
    cyc(1'b1);
    check("midrst_x", pixel_x, 799);
    check("midrst_y", pixel_y, 524);
    check("midrst_tick", pixel_tick, 0);
    check("midrst_video", video_on, 0);
    check("midrst_hsync", hsync, 1);
    rst_n = 1'b1;
    cyc(1'b0);
    check("post_rst_hold_x", pixel_x, 799);
    cyc(1'b1);
    check("post_rst_x", pixel_x, 0);
    check("post_rst_y", pixel_y, 0);
    check("post_rst_fs", frame_start, 1);
    check("post_rst_tick", pixel_tick, 1);
    cyc(1'b0);

    // Two whole frames of the small raster.
    s_fs_cnt = 0; s_vs_cnt = 0; s_vs_min = 99; s_vs_max = -1; s_vid_cnt = 0;
    wrap_ok = 0; d_vs_cnt = 0; d_fs_cnt = 0; prev_x = 0; prev_y = 0;
    for (int k = 1; k <= 224; k++) begin
      cyc(1'b1);
      if (s_fs === 1'b1) begin
        s_fs_cnt++;
        if (prev_x == 13 && prev_y == 7 && s_x === 10'd0 && s_y === 10'd0) wrap_ok++;
      end
      if (s_vsync === 1'b0) begin
        s_vs_cnt++;
        if (int'(s_y) < s_vs_min) s_vs_min = int'(s_y);
        if (int'(s_y) > s_vs_max) s_vs_max = int'(s_y);
      end
      s_vid_cnt += int'(s_video);
      d_vs_cnt += int'(!vsync);
      d_fs_cnt += int'(frame_start);
      prev_x = int'(s_x);
      prev_y = int'(s_y);
      cyc(1'b0);
    end
    check("small_fs_count", s_fs_cnt, 2);
    check("small_frame_wrap", wrap_ok, 2);
    check("small_vsync_count", s_vs_cnt, 56);
    check("small_vsync_min_y", s_vs_min, 5);
    check("small_vsync_max_y", s_vs_max, 6);
    check("small_video_count", s_vid_cnt, 64);
    check("small_end_x", s_x, 0);
    check("small_end_y", s_y, 0);
    check("dflt_vsync_idle", d_vs_cnt, 0);
    check("dflt_fs_idle", d_fs_cnt, 0);
    check("dflt_end_x", pixel_x, 224);
    check("dflt_end_y", pixel_y, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
